// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port unified memory between an instruction
// fetch port (read-only) and a data port (read/write); one access in flight at a time.
module mem_arbiter #(
    parameter int LAT  = 2,
    parameter int MAXD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        iready,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        istall,
    output logic        dstall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester raises req with addr/dwe/dwdata and holds all of them
    // stable until its one-cycle ready pulse; request fields are latched at grant.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  dstreak;
    logic [3:0]  dstreak_nxt;
    logic [2:0]  cnt;
    logic        acc_we;
    logic        ielig;
    logic        delig;
    logic        grant_i;
    logic        grant_d;
    logic        done;

    assign ielig     = ireq & ~iready;
    assign delig     = dreq & ~dready;
    assign done      = (state != IDLE) && (cnt == 3'(LAT));
    assign istall    = ireq & ~iready;
    assign dstall    = dreq & ~dready;
    assign dbg_state = state;

    // The cycle carrying a ready pulse is a turnaround cycle: no grant is made in it.
    always_comb begin
        state_nxt   = state;
        dstreak_nxt = dstreak;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        case (state)
            IDLE: begin
                if (!(iready || dready)) begin
                    if (delig && !(ielig && (dstreak == 4'(MAXD)))) begin
                        grant_d   = 1'b1;
                        state_nxt = BUSY_D;
                        if (ielig && (dstreak != 4'(MAXD))) begin
                            dstreak_nxt = dstreak + 4'd1;
                        end
                    end else if (ielig) begin
                        grant_i     = 1'b1;
                        state_nxt   = BUSY_I;
                        dstreak_nxt = 4'd0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            dstreak <= 4'd0;
        end else begin
            state   <= state_nxt;
            dstreak <= dstreak_nxt;
        end
    end

    // cnt is 0 in the mem_en cycle, so read data is on mem_rdata when cnt == LAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            iready    <= 1'b0;
            dready    <= 1'b0;
            irdata    <= 32'd0;
            drdata    <= 32'd0;
            cnt       <= 3'd0;
            acc_we    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            iready <= 1'b0;
            dready <= 1'b0;
            if (grant_d) begin
                mem_en    <= 1'b1;
                mem_we    <= dwe;
                mem_addr  <= daddr;
                mem_wdata <= dwdata;
                acc_we    <= dwe;
                cnt       <= 3'd0;
            end else if (grant_i) begin
                mem_en   <= 1'b1;
                mem_addr <= iaddr;
                acc_we   <= 1'b0;
                cnt      <= 3'd0;
            end else if (state != IDLE) begin
                cnt <= cnt + 3'd1;
            end
            if (done) begin
                if (state == BUSY_I) begin
                    irdata <= mem_rdata;
                    iready <= 1'b1;
                end else begin
                    if (!acc_we) begin
                        drdata <= mem_rdata;
                    end
                    dready <= 1'b1;
                end
            end
        end
    end

endmodule
